// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the memory stage: one-hot memory-op bit indices,
// register address width and the memory-stage state encoding.
// -----------------------------------------------------------------------------
package core_pkg;

    // One-hot memory access size; bit index into mem_pipe_mem_opcode.
    localparam int MEM_OP_WIDTH  = 4;
    localparam int MEM_OP_BYTE   = 0;
    localparam int MEM_OP_HALF   = 1;
    localparam int MEM_OP_WORD   = 2;
    localparam int MEM_OP_DOUBLE = 3;

    // Architectural register file address width.
    localparam int REG_AW = 5;

    // RUN : normal flow, loads wait for their data-RAM beat.
    // HOLD: a load beat was captured while WB stalled; hold_buf owns the data.
    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_stage_v2_if.sv
// -----------------------------------------------------------------------------
// mem_stage_v2_if
// Bundles every memory-stage signal except clock and reset:
//   mem_pipe_* : EX->MEM handshake and payload
//   wb_pipe_*  : MEM->WB handshake and registered payload
//   mem_rd_*   : forwarding / hazard information towards ID
//   dram_*     : in-order data-RAM read response
// Modports: slave = the memory stage, master = its surroundings.
// -----------------------------------------------------------------------------
interface mem_stage_v2_if #(
    parameter int XLEN = 32
);
    import core_pkg::*;

    logic                    mem_pipe_valid;
    logic                    mem_pipe_ready;
    logic                    mem_pipe_flush;
    logic [XLEN-1:0]         mem_pipe_pc;
    logic [XLEN-1:0]         mem_pipe_instruction;
    logic                    mem_pipe_mem_read;
    logic [MEM_OP_WIDTH-1:0] mem_pipe_mem_opcode;
    logic                    mem_pipe_unsign;
    logic                    mem_pipe_rd_write;
    logic [REG_AW-1:0]       mem_pipe_rd_addr;
    logic [XLEN-1:0]         mem_pipe_alu_result;

    logic                    wb_pipe_ready;
    logic                    wb_pipe_flush;
    logic                    wb_pipe_valid;
    logic [XLEN-1:0]         wb_pipe_pc;
    logic [XLEN-1:0]         wb_pipe_instruction;
    logic                    wb_pipe_rd_write;
    logic [REG_AW-1:0]       wb_pipe_rd_addr;
    logic [XLEN-1:0]         wb_pipe_rd_data;

    logic                    mem_rd_write;
    logic [REG_AW-1:0]       mem_rd_addr;
    logic [XLEN-1:0]         mem_rd_wdata;
    logic                    mem_rd_pending;

    logic                    dram_data_ok;
    logic [XLEN-1:0]         dram_rdata;

    modport slave (
        input  mem_pipe_valid, mem_pipe_pc, mem_pipe_instruction, mem_pipe_mem_read,
               mem_pipe_mem_opcode, mem_pipe_unsign, mem_pipe_rd_write, mem_pipe_rd_addr,
               mem_pipe_alu_result, wb_pipe_ready, wb_pipe_flush, dram_data_ok, dram_rdata,
        output mem_pipe_ready, mem_pipe_flush, wb_pipe_valid, wb_pipe_pc, wb_pipe_instruction,
               wb_pipe_rd_write, wb_pipe_rd_addr, wb_pipe_rd_data, mem_rd_write, mem_rd_addr,
               mem_rd_wdata, mem_rd_pending
    );

    modport master (
        output mem_pipe_valid, mem_pipe_pc, mem_pipe_instruction, mem_pipe_mem_read,
               mem_pipe_mem_opcode, mem_pipe_unsign, mem_pipe_rd_write, mem_pipe_rd_addr,
               mem_pipe_alu_result, wb_pipe_ready, wb_pipe_flush, dram_data_ok, dram_rdata,
        input  mem_pipe_ready, mem_pipe_flush, wb_pipe_valid, wb_pipe_pc, wb_pipe_instruction,
               wb_pipe_rd_write, wb_pipe_rd_addr, wb_pipe_rd_data, mem_rd_write, mem_rd_addr,
               mem_rd_wdata, mem_rd_pending
    );

endinterface

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load-data lane select and sign/zero extension.
//   rdata_i  : raw data-RAM beat (XLEN bits, naturally aligned)
//   offset_i : byte offset of the load inside the beat
//   opcode_i : one-hot access size (BYTE/HALF/WORD/DOUBLE)
//   unsign_i : 1 = zero-extend, 0 = sign-extend
//   data_o   : aligned, extended load result
// WORD is only extended when XLEN=64; DOUBLE under XLEN=32 returns zero.
// -----------------------------------------------------------------------------
module load_align
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]            rdata_i,
    input  logic [$clog2(XLEN/8)-1:0]  offset_i,
    input  logic [MEM_OP_WIDTH-1:0]    opcode_i,
    input  logic                       unsign_i,
    output logic [XLEN-1:0]            data_o
);

    localparam int OFF_W = $clog2(XLEN/8);

    logic [OFF_W-1:0] half_off;
    logic [OFF_W-1:0] word_off;
    logic [7:0]       byte_lane;
    logic [15:0]      half_lane;
    logic [31:0]      word_lane;

    // Lane bases: halves ignore offset bit 0, words use only offset bit 2
    // (a 32-bit beat holds a single word, so its word lane is always 0).
    assign half_off = {offset_i[OFF_W-1:1], 1'b0};
    assign word_off = (XLEN == 64) ? {offset_i[OFF_W-1], {(OFF_W-1){1'b0}}} : '0;

    assign byte_lane = rdata_i[{offset_i, 3'b000} +: 8];
    assign half_lane = rdata_i[{half_off, 3'b000} +: 16];
    assign word_lane = rdata_i[{word_off, 3'b000} +: 32];

    // Fill the whole word with the extension bit, then overlay the lane.
    always_comb begin
        // NOTE: every path starts from a default so no latch is inferred.
        data_o = '0;
        if (opcode_i[MEM_OP_BYTE]) begin
            data_o      = {XLEN{~unsign_i & byte_lane[7]}};
            data_o[7:0] = byte_lane;
        end else if (opcode_i[MEM_OP_HALF]) begin
            data_o       = {XLEN{~unsign_i & half_lane[15]}};
            data_o[15:0] = half_lane;
        end else if (opcode_i[MEM_OP_WORD]) begin
            data_o       = {XLEN{(XLEN == 64) & ~unsign_i & word_lane[31]}};
            data_o[31:0] = word_lane;
        end else if (opcode_i[MEM_OP_DOUBLE] && (XLEN == 64)) begin
            data_o = rdata_i;
        end
    end

endmodule

// File: rtl/mem_stage_v2.sv
// -----------------------------------------------------------------------------
// mem_stage_v2
// Memory pipeline stage between the EX->MEM and MEM->WB registers.
//   clk   : clock
//   rst_b : asynchronous active-low reset
//   bus   : mem_stage_v2_if.slave (EX->MEM, MEM->WB, ID forwarding, data RAM)
// Aligns/extends load data, parks a returned load beat in hold_buf while WB
// stalls, discards data-RAM beats that belong to flushed loads (drop_cnt) and
// tells ID when a load result is still outstanding.
// XLEN must be 32 or 64.
// -----------------------------------------------------------------------------
module mem_stage_v2
    import core_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_DROP = 3
) (
    input  logic          clk,
    input  logic          rst_b,
    mem_stage_v2_if.slave bus
);

    localparam int OFF_W  = $clog2(XLEN/8);
    // One spare bit beyond MAX_DROP keeps the overflow assertion meaningful.
    localparam int DROP_W = $clog2(MAX_DROP + 2);

    mem_state_e        state_q, state_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [XLEN-1:0]   hold_buf_q, hold_buf_d;

    logic              wb_valid_q;
    logic [XLEN-1:0]   wb_pc_q;
    logic [XLEN-1:0]   wb_instr_q;
    logic              wb_rd_write_q;
    logic [REG_AW-1:0] wb_rd_addr_q;
    logic [XLEN-1:0]   wb_rd_data_q;

    logic              mem_valid;
    logic              is_load;
    logic              owned_rsp;
    logic              drop_inc;
    logic              drop_dec;
    logic              in_hold;
    logic              done;
    logic              pending;
    logic              capture;
    logic [XLEN-1:0]   aligned;
    logic [XLEN-1:0]   rd_data;

    load_align #(.XLEN(XLEN)) u_align (
        .rdata_i  (bus.dram_rdata),
        .offset_i (bus.mem_pipe_alu_result[OFF_W-1:0]),
        .opcode_i (bus.mem_pipe_mem_opcode),
        .unsign_i (bus.mem_pipe_unsign),
        .data_o   (aligned)
    );

    assign mem_valid = bus.mem_pipe_valid & ~bus.wb_pipe_flush;
    assign is_load   = bus.mem_pipe_valid & bus.mem_pipe_mem_read;

    // A beat belongs to the load in MEM only when no flushed load is still
    // owed a response and that load has not already captured its data.
    assign owned_rsp = bus.dram_data_ok & (drop_cnt_q == '0) & is_load & (state_q == RUN);

    // A load flushed before its beat arrives leaves one beat to discard.
    // In HOLD, or when the beat lands in the flush cycle, nothing is owed.
    assign drop_inc = bus.wb_pipe_flush & is_load & (state_q == RUN) & ~owned_rsp;
    assign drop_dec = bus.dram_data_ok & (drop_cnt_q != '0);

    // ---------------------------------------------------------------- FSM --
    always_ff @(posedge clk or negedge rst_b) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (!rst_b) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (mem_valid & owned_rsp & ~bus.wb_pipe_ready) state_d = HOLD;
            HOLD:    if (bus.wb_pipe_ready | bus.wb_pipe_flush)      state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        in_hold = (state_q == HOLD);
        capture = (state_q == RUN) & (state_d == HOLD);
        done    = ~bus.mem_pipe_mem_read | in_hold | owned_rsp;
        pending = is_load & ~done;
        if (in_hold) begin
            rd_data = hold_buf_q;
        end else if (bus.mem_pipe_mem_read) begin
            rd_data = aligned;
        end else begin
            rd_data = bus.mem_pipe_alu_result;
        end
    end

    // ------------------------------------------------- drop counter / hold --
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_inc && !drop_dec && (drop_cnt_q < DROP_W'(MAX_DROP))) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end else if (drop_dec && !drop_inc) begin
            drop_cnt_d = drop_cnt_q - 1'b1;
        end
        hold_buf_d = capture ? aligned : hold_buf_q;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            drop_cnt_q <= '0;
            hold_buf_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            hold_buf_q <= hold_buf_d;
        end
    end

    // ------------------------------------------------------- MEM->WB regs --
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wb_valid_q    <= 1'b0;
            wb_pc_q       <= '0;
            wb_instr_q    <= '0;
            wb_rd_write_q <= 1'b0;
            wb_rd_addr_q  <= '0;
            wb_rd_data_q  <= '0;
        end else if (bus.wb_pipe_ready) begin
            wb_valid_q    <= mem_valid & done;
            wb_pc_q       <= bus.mem_pipe_pc;
            wb_instr_q    <= bus.mem_pipe_instruction;
            wb_rd_write_q <= bus.mem_pipe_rd_write;
            wb_rd_addr_q  <= bus.mem_pipe_rd_addr;
            wb_rd_data_q  <= rd_data;
        end
    end

    // ------------------------------------------------------------ outputs --
    assign bus.mem_pipe_ready      = ~mem_valid | (bus.wb_pipe_ready & done);
    assign bus.mem_pipe_flush      = bus.wb_pipe_flush;

    assign bus.wb_pipe_valid       = wb_valid_q;
    assign bus.wb_pipe_pc          = wb_pc_q;
    assign bus.wb_pipe_instruction = wb_instr_q;
    assign bus.wb_pipe_rd_write    = wb_rd_write_q;
    assign bus.wb_pipe_rd_addr     = wb_rd_addr_q;
    assign bus.wb_pipe_rd_data     = wb_rd_data_q;

    assign bus.mem_rd_pending      = pending;
    assign bus.mem_rd_write        = bus.mem_pipe_valid & bus.mem_pipe_rd_write & ~pending;
    assign bus.mem_rd_addr         = bus.mem_pipe_rd_addr;
    assign bus.mem_rd_wdata        = rd_data;

    a_drop_cnt_bound : assert property (
        @(posedge clk) disable iff (!rst_b) drop_cnt_q <= DROP_W'(MAX_DROP)
    );

endmodule

// File: tb/tb_mem_stage_v2.sv
module tb_mem_stage_v2;
    import core_pkg::*;

    localparam logic [3:0] OP_B = 4'(1 << MEM_OP_BYTE);
    localparam logic [3:0] OP_H = 4'(1 << MEM_OP_HALF);
    localparam logic [3:0] OP_W = 4'(1 << MEM_OP_WORD);
    localparam logic [3:0] OP_D = 4'(1 << MEM_OP_DOUBLE);

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    mem_stage_v2_if #(.XLEN(64)) bus64 ();
    mem_stage_v2_if #(.XLEN(32)) bus32 ();

    mem_stage_v2 #(.XLEN(64), .MAX_DROP(3)) dut   (.clk(clk), .rst_b(rst_b), .bus(bus64));
    mem_stage_v2 #(.XLEN(32), .MAX_DROP(3)) dut32 (.clk(clk), .rst_b(rst_b), .bus(bus32));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_exp_t;
    wb_exp_t sb_q[$];

    typedef struct {
        logic [3:0]  op;
        logic        uns;
        logic [2:0]  off;
        logic [63:0] rdata;
        logic [63:0] exp;
    } ld_vec_t;

    ld_vec_t v64[8] = '{
        '{OP_W, 1'b1, 3'd4, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_DEAD_BEEF},
        '{OP_D, 1'b0, 3'd0, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001},
        '{OP_W, 1'b0, 3'd4, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_DEAD_BEEF},
        '{OP_W, 1'b0, 3'd0, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_0001},
        '{OP_H, 1'b0, 3'd6, 64'h8001_2345_6789_ABCD, 64'hFFFF_FFFF_FFFF_8001},
        '{OP_H, 1'b1, 3'd2, 64'h8001_2345_6789_ABCD, 64'h0000_0000_0000_6789},
        '{OP_B, 1'b0, 3'd1, 64'h8001_2345_6789_ABCD, 64'hFFFF_FFFF_FFFF_FFAB},
        '{OP_B, 1'b1, 3'd7, 64'h8001_2345_6789_ABCD, 64'h0000_0000_0000_0080}
    };

    ld_vec_t v32[6] = '{
        '{OP_B, 1'b0, 3'd3, 64'h80FF_1234, 64'hFFFF_FF80},
        '{OP_B, 1'b1, 3'd3, 64'h80FF_1234, 64'h0000_0080},
        '{OP_H, 1'b0, 3'd2, 64'h80FF_1234, 64'hFFFF_80FF},
        '{OP_H, 1'b1, 3'd0, 64'h80FF_1234, 64'h0000_1234},
        '{OP_W, 1'b0, 3'd0, 64'h80FF_1234, 64'h80FF_1234},
        '{OP_D, 1'b0, 3'd0, 64'h80FF_1234, 64'h0000_0000}
    };

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive64(input logic [63:0] pc, input logic ld, input logic [3:0] op,
                           input logic uns, input logic [4:0] rd, input logic [63:0] alu);
        bus64.mem_pipe_valid       = 1'b1;
        bus64.mem_pipe_pc          = pc;
        bus64.mem_pipe_instruction = 64'h0000_0000_0000_0013 ^ pc;
        bus64.mem_pipe_mem_read    = ld;
        bus64.mem_pipe_mem_opcode  = op;
        bus64.mem_pipe_unsign      = uns;
        bus64.mem_pipe_rd_write    = 1'b1;
        bus64.mem_pipe_rd_addr     = rd;
        bus64.mem_pipe_alu_result  = alu;
    endtask

    task automatic rsp64(input logic ok, input logic [63:0] data);
        bus64.dram_data_ok = ok;
        bus64.dram_rdata   = data;
    endtask

    task automatic idle64();
        bus64.mem_pipe_valid    = 1'b0;
        bus64.mem_pipe_mem_read = 1'b0;
        bus64.wb_pipe_flush     = 1'b0;
        bus64.dram_data_ok      = 1'b0;
    endtask

    task automatic push(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] data);
        wb_exp_t e;
        e.pc   = pc;
        e.rd   = rd;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every instruction WB accepts must match the oldest expectation.
    always @(negedge clk) begin
        wb_exp_t e;
        if (rst_b && bus64.wb_pipe_valid && bus64.wb_pipe_ready) begin
            if (sb_q.size() == 0) begin
                check("wb_unexpected_valid", 64'(bus64.wb_pipe_valid), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_pc",   bus64.wb_pipe_pc,           e.pc);
                check("sb_rd",   64'(bus64.wb_pipe_rd_addr), 64'(e.rd));
                check("sb_data", bus64.wb_pipe_rd_data,      e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------------------------------------------------- reset --
        rst_b = 1'b0;
        idle64();
        drive64(64'h0, 1'b0, 4'h0, 1'b0, 5'd0, 64'h0);
        bus64.mem_pipe_valid = 1'b0;
        bus64.wb_pipe_ready  = 1'b1;
        bus64.dram_rdata     = '0;
        bus32.mem_pipe_valid = 1'b0;   bus32.mem_pipe_pc = '0;
        bus32.mem_pipe_instruction = '0; bus32.mem_pipe_mem_read = 1'b0;
        bus32.mem_pipe_mem_opcode = '0; bus32.mem_pipe_unsign = 1'b0;
        bus32.mem_pipe_rd_write = 1'b0; bus32.mem_pipe_rd_addr = '0;
        bus32.mem_pipe_alu_result = '0; bus32.wb_pipe_ready = 1'b1;
        bus32.wb_pipe_flush = 1'b0;    bus32.dram_data_ok = 1'b0; bus32.dram_rdata = '0;
        #12;
        check("rst_wb_valid",   64'(bus64.wb_pipe_valid), 64'd0);
        check("rst_wb_data",    bus64.wb_pipe_rd_data,    64'd0);
        check("rst_state",      64'(dut.state_q),         64'(RUN));
        check("rst_drop",       64'(dut.drop_cnt_q),      64'd0);
        check("rst_ready",      64'(bus64.mem_pipe_ready), 64'd1);
        check("rst_wb_valid32", 64'(bus32.wb_pipe_valid), 64'd0);
        rst_b = 1'b1;

        // ------------------------------------------------ non-load, 1 cycle --
        tick();
        drive64(64'h100, 1'b0, 4'h0, 1'b0, 5'd5, 64'h1234_5678_9ABC_DEF0);
        settle();
        check("alu_ready",   64'(bus64.mem_pipe_ready), 64'd1);
        check("alu_fwd_wr",  64'(bus64.mem_rd_write),   64'd1);
        check("alu_fwd_dat", bus64.mem_rd_wdata,        64'h1234_5678_9ABC_DEF0);
        check("alu_pending", 64'(bus64.mem_rd_pending), 64'd0);
        push(64'h100, 5'd5, 64'h1234_5678_9ABC_DEF0);
        tick();
        idle64();
        settle();
        check("alu_wb_valid", 64'(bus64.wb_pipe_valid), 64'd1);
        check("alu_wb_data",  bus64.wb_pipe_rd_data,     64'h1234_5678_9ABC_DEF0);

        // ------------------------------------------- lwu with one wait cycle --
        tick();
        drive64(64'h104, 1'b1, OP_W, 1'b1, 5'd6, 64'h1004);
        rsp64(1'b0, 64'h0);
        settle();
        check("lwu_pending", 64'(bus64.mem_rd_pending), 64'd1);
        check("lwu_ready0",  64'(bus64.mem_pipe_ready), 64'd0);
        check("lwu_fwd_wr0", 64'(bus64.mem_rd_write),   64'd0);
        tick();
        rsp64(1'b1, 64'hDEAD_BEEF_0000_0001);
        settle();
        check("lwu_ready1", 64'(bus64.mem_pipe_ready), 64'd1);
        check("lwu_fwd",    bus64.mem_rd_wdata,        64'h0000_0000_DEAD_BEEF);
        push(64'h104, 5'd6, 64'h0000_0000_DEAD_BEEF);
        tick();
        idle64();
        settle();
        check("lwu_wb_valid", 64'(bus64.wb_pipe_valid), 64'd1);

        // ----------------------------------------- back-to-back XLEN=64 loads --
        for (int i = 0; i < 8; i++) begin
            tick();
            drive64(64'h200 + 64'(i * 4), 1'b1, v64[i].op, v64[i].uns, 5'(i + 1),
                    64'h1000 + 64'(v64[i].off));
            rsp64(1'b1, v64[i].rdata);
            settle();
            check("ld64_ready", 64'(bus64.mem_pipe_ready), 64'd1);
            check("ld64_fwd",   bus64.mem_rd_wdata,        v64[i].exp);
            push(64'h200 + 64'(i * 4), 5'(i + 1), v64[i].exp);
        end
        tick();
        idle64();

        // ------------------------------------------------ XLEN=32 alignment --
        for (int i = 0; i < 6; i++) begin
            tick();
            bus32.mem_pipe_valid      = 1'b1;
            bus32.mem_pipe_pc         = 32'h800 + 32'(i * 4);
            bus32.mem_pipe_mem_read   = 1'b1;
            bus32.mem_pipe_mem_opcode = v32[i].op;
            bus32.mem_pipe_unsign     = v32[i].uns;
            bus32.mem_pipe_rd_write   = 1'b1;
            bus32.mem_pipe_rd_addr    = 5'(i + 1);
            bus32.mem_pipe_alu_result = 32'h1000 + 32'(v32[i].off);
            bus32.dram_data_ok        = 1'b1;
            bus32.dram_rdata          = v32[i].rdata[31:0];
            settle();
            check("ld32_fwd", 64'(bus32.mem_rd_wdata), v32[i].exp);
            tick();
            bus32.mem_pipe_valid = 1'b0;
            bus32.dram_data_ok   = 1'b0;
            settle();
            check("ld32_wb_data", 64'(bus32.wb_pipe_rd_data), v32[i].exp);
            check("ld32_wb_pc",   64'(bus32.wb_pipe_pc),      64'h800 + 64'(i * 4));
        end

        // --------------------------------------------------- HOLD under stall --
        tick();
        drive64(64'h300, 1'b1, OP_W, 1'b0, 5'd7, 64'h4000);
        rsp64(1'b1, 64'h0000_0000_1234_5678);
        bus64.wb_pipe_ready = 1'b0;
        settle();
        check("hold_ready_a",   64'(bus64.mem_pipe_ready), 64'd0);
        check("hold_pending_a", 64'(bus64.mem_rd_pending), 64'd0);
        tick();
        rsp64(1'b0, 64'h0);
        settle();
        check("hold_state",     64'(dut.state_q),          64'(HOLD));
        check("hold_pending_b", 64'(bus64.mem_rd_pending), 64'd0);
        check("hold_fwd_wr",    64'(bus64.mem_rd_write),   64'd1);
        check("hold_fwd_b",     bus64.mem_rd_wdata,        64'h0000_0000_1234_5678);
        tick();
        rsp64(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        settle();
        check("hold_fwd_spur",  bus64.mem_rd_wdata,        64'h0000_0000_1234_5678);
        tick();
        rsp64(1'b0, 64'h0);
        bus64.wb_pipe_ready = 1'b1;
        settle();
        check("hold_drop_spur", 64'(dut.drop_cnt_q),       64'd0);
        check("hold_ready_d",   64'(bus64.mem_pipe_ready), 64'd1);
        push(64'h300, 5'd7, 64'h0000_0000_1234_5678);
        tick();
        idle64();
        settle();
        check("hold_wb_valid",  64'(bus64.wb_pipe_valid),  64'd1);
        check("hold_wb_data",   bus64.wb_pipe_rd_data,     64'h0000_0000_1234_5678);
        check("hold_exit",      64'(dut.state_q),          64'(RUN));

        // ------------------------------------- two flushed loads, then a lw --
        tick();
        drive64(64'h400, 1'b1, OP_W, 1'b0, 5'd10, 64'h3000);
        settle();
        check("drop_pending", 64'(bus64.mem_rd_pending), 64'd1);
        tick();
        bus64.wb_pipe_flush = 1'b1;
        settle();
        check("drop_flush_out", 64'(bus64.mem_pipe_flush), 64'd1);
        check("drop_flush_rdy", 64'(bus64.mem_pipe_ready), 64'd1);
        tick();
        bus64.wb_pipe_flush = 1'b0;
        drive64(64'h404, 1'b1, OP_W, 1'b0, 5'd11, 64'h3004);
        settle();
        check("drop_cnt1", 64'(dut.drop_cnt_q), 64'd1);
        tick();
        bus64.wb_pipe_flush = 1'b1;
        tick();
        idle64();
        settle();
        check("drop_cnt2", 64'(dut.drop_cnt_q), 64'd2);
        tick();
        drive64(64'h408, 1'b1, OP_W, 1'b0, 5'd12, 64'h3008);
        rsp64(1'b1, 64'hAAAA_AAAA_AAAA_AAAA);
        settle();
        check("drop_skip1_rdy", 64'(bus64.mem_pipe_ready), 64'd0);
        check("drop_skip1_pnd", 64'(bus64.mem_rd_pending), 64'd1);
        tick();
        rsp64(1'b1, 64'hBBBB_BBBB_BBBB_BBBB);
        settle();
        check("drop_skip2_cnt", 64'(dut.drop_cnt_q),       64'd1);
        check("drop_skip2_rdy", 64'(bus64.mem_pipe_ready), 64'd0);
        tick();
        rsp64(1'b1, 64'h0000_0000_0000_00C3);
        settle();
        check("drop_own_cnt", 64'(dut.drop_cnt_q),       64'd0);
        check("drop_own_rdy", 64'(bus64.mem_pipe_ready), 64'd1);
        check("drop_own_fwd", bus64.mem_rd_wdata,        64'h0000_0000_0000_00C3);
        push(64'h408, 5'd12, 64'h0000_0000_0000_00C3);
        tick();
        idle64();
        settle();
        check("drop_wb_data", bus64.wb_pipe_rd_data, 64'h0000_0000_0000_00C3);

        // ------------------------------- simultaneous inc/dec and saturation --
        tick();
        drive64(64'h500, 1'b1, OP_W, 1'b0, 5'd13, 64'h5000);
        bus64.wb_pipe_flush = 1'b1;
        tick();
        idle64();
        settle();
        check("sat_cnt1", 64'(dut.drop_cnt_q), 64'd1);
        tick();
        drive64(64'h504, 1'b1, OP_W, 1'b0, 5'd13, 64'h5004);
        bus64.wb_pipe_flush = 1'b1;
        rsp64(1'b1, 64'h1);
        tick();
        idle64();
        settle();
        check("sat_inc_dec", 64'(dut.drop_cnt_q), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            drive64(64'h508 + 64'(i * 4), 1'b1, OP_W, 1'b0, 5'd13, 64'h5008);
            bus64.wb_pipe_flush = 1'b1;
        end
        tick();
        idle64();
        settle();
        check("sat_cnt_max", 64'(dut.drop_cnt_q), 64'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            rsp64(1'b1, 64'h2);
            tick();
            rsp64(1'b0, 64'h0);
        end
        settle();
        check("sat_drained", 64'(dut.drop_cnt_q), 64'd0);

        // ---------------------------------- flush coincident with owned beat --
        tick();
        drive64(64'h600, 1'b1, OP_W, 1'b0, 5'd14, 64'h6000);
        bus64.wb_pipe_flush = 1'b1;
        rsp64(1'b1, 64'h1234);
        settle();
        check("fo_ready", 64'(bus64.mem_pipe_ready), 64'd1);
        tick();
        idle64();
        settle();
        check("fo_drop",     64'(dut.drop_cnt_q),      64'd0);
        check("fo_wb_valid", 64'(bus64.wb_pipe_valid), 64'd0);

        // ---------------------------------------- async reset during HOLD --
        tick();
        drive64(64'h700, 1'b0, 4'h0, 1'b0, 5'd15, 64'h77);
        tick();
        drive64(64'h704, 1'b1, OP_W, 1'b0, 5'd16, 64'h7000);
        rsp64(1'b1, 64'h5555);
        bus64.wb_pipe_ready = 1'b0;
        tick();
        rsp64(1'b0, 64'h0);
        settle();
        check("ar_state_hold", 64'(dut.state_q),         64'(HOLD));
        check("ar_wb_valid1",  64'(bus64.wb_pipe_valid), 64'd1);
        #1 rst_b = 1'b0;
        #1;
        check("ar_wb_valid0", 64'(bus64.wb_pipe_valid), 64'd0);
        check("ar_wb_pc",     bus64.wb_pipe_pc,          64'd0);
        check("ar_state",     64'(dut.state_q),          64'(RUN));
        check("ar_drop",      64'(dut.drop_cnt_q),       64'd0);
        check("ar_hold_buf",  dut.hold_buf_q,            64'd0);
        idle64();
        bus64.wb_pipe_ready = 1'b1;
        rst_b = 1'b1;

        tick();
        tick();
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
